// File: rtl/snake_score_display_ctrl_if.sv
// Score update handshake and display pin bundle between the game core and the scoreboard sequencer.
interface snake_score_display_ctrl_if #(
    parameter int unsigned SCORE_WIDTH = 14
);
    logic [SCORE_WIDTH-1:0] i_Score;
    logic                   i_ScoreValid;
    logic                   o_Busy;
    logic                   o_Saturated;
    logic [3:0]             o_Anode;
    logic [6:0]             o_Segments;

    modport master (
        output i_Score,
        output i_ScoreValid,
        input  o_Busy,
        input  o_Saturated,
        input  o_Anode,
        input  o_Segments
    );

    modport slave (
        input  i_Score,
        input  i_ScoreValid,
        output o_Busy,
        output o_Saturated,
        output o_Anode,
        output o_Segments
    );
endinterface

// File: rtl/snake_score_display_ctrl.sv
// Four-digit seven-segment scoreboard: score capture with pending slot, serial double-dabble, digit scan.
// Leading-zero blanking is enabled by defining SNAKE_SCORE_LZB_EN.
module snake_score_display_ctrl #(
    parameter int unsigned SCORE_WIDTH = 14,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    snake_score_display_ctrl_if.slave bus
);
    localparam int unsigned CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BCD_W     = 16;
    localparam int unsigned BIT_CNT_W = $clog2(SCORE_WIDTH + 1);
    localparam logic [SCORE_WIDTH-1:0] MAX_SCORE = SCORE_WIDTH'(9999);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD
    } state_e;

    state_e                 state_q;
    logic [SCORE_WIDTH-1:0] shift_q;
    logic [SCORE_WIDTH-1:0] pending_val_q;
    logic [SCORE_WIDTH-1:0] accept_val;
    logic [BCD_W-1:0]       bcd_q;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       disp_q;
    logic [BCD_W-1:0]       disp_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic                   sat_flag_q;
    logic                   pending_q;
    logic                   busy_q;
    logic                   sat_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   cnt_wrap;
    logic [1:0]             sel_q;
    logic [1:0]             sel_d;
    logic [3:0]             anode_q;
    logic [3:0]             anode_d;
    logic [3:0]             lead_zero;
    logic [3:0]             digit_d;
    logic [6:0]             seg_q;
    logic [6:0]             seg_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    // A fresh strobe always beats the parked pending value.
    assign accept_val = bus.i_ScoreValid ? bus.i_Score : pending_val_q;

    // Double-dabble correction: nibbles of 5 or more get +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < 4; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) begin
                bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
            end
        end
    end

    // Conversion sequencer with pending slot for updates arriving while busy.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            bcd_q         <= '0;
            bit_cnt_q     <= '0;
            sat_flag_q    <= 1'b0;
            pending_q     <= 1'b0;
            pending_val_q <= '0;
            busy_q        <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_ScoreValid || pending_q) begin
                        shift_q    <= (accept_val > MAX_SCORE) ? MAX_SCORE : accept_val;
                        sat_flag_q <= (accept_val > MAX_SCORE);
                        bcd_q      <= '0;
                        bit_cnt_q  <= '0;
                        pending_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {bcd_q, shift_q} <= {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
                    bit_cnt_q        <= bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(SCORE_WIDTH - 1)) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sat_q   <= sat_flag_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if ((state_q != S_IDLE) && bus.i_ScoreValid) begin
                pending_q     <= 1'b1;
                pending_val_q <= bus.i_Score;
            end
        end
    end

`ifdef SNAKE_SCORE_LZB_EN
    // A digit blanks only when it and every more significant digit are zero.
    always_comb begin
        lead_zero    = 4'b0000;
        lead_zero[3] = (disp_d[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (disp_d[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (disp_d[7:4] == 4'd0);
    end
`else
    assign lead_zero = 4'b0000;
`endif

    // Next display, scan slot and segment pattern; the new value shows on the LOAD edge itself.
    always_comb begin
        disp_d   = (state_q == S_LOAD) ? bcd_q : disp_q;
        cnt_wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        sel_d    = cnt_wrap ? sel_q + 2'd1 : sel_q;
        anode_d  = ~(4'b0001 << sel_d);
        digit_d  = disp_d[{sel_d, 2'b00} +: 4];
        seg_d    = lead_zero[sel_d] ? SEG_BLANK : seg_decode(digit_d);
    end

    // Free-running scan; anode and segments update together.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            disp_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            anode_q <= 4'b1110;
            seg_q   <= SEG_ZERO;
        end else begin
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.o_Busy      = busy_q;
    assign bus.o_Saturated = sat_q;
    assign bus.o_Anode     = anode_q;
    assign bus.o_Segments  = seg_q;

endmodule
